wbrrarbiter: RTL and testbench
==============================

Name: wbrrarbiter

Overview:
Round-robin Wishbone arbiter that shares one slave port between NM masters, for use where several masters reach a single resource (e.g. one crossbar slave port or a shared RAM).
- Grants are registered and held for the whole master cycle (CYC-level locking).
- Rotating priority prevents starvation.
- A bus watchdog turns a hung slave into an error response.

Parameters:
NM, 4, number of masters (2..8)
AW, 32, address width
DW, 32, data width
SW, DW/8, byte-select width
TIMEOUT, 255, cycles with STB high and no ACK/ERR before watchdog error (1..65535)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_mcyc  in  NM  master CYC
i_mstb  in  NM  master STB
i_mwe  in  NM  master WE
i_maddr  in  NM*AW  master addresses, master m at [m*AW +: AW]
i_mdata  in  NM*DW  master write data
i_msel  in  NM*SW  master byte selects
o_mack  out  NM  per-master ACK
o_mdata  out  DW  read data, broadcast to all masters
o_merr  out  NM  per-master ERR
o_scyc  out  1  slave CYC
o_sstb  out  1  slave STB
o_swe  out  1  slave WE
o_saddr  out  AW  slave address
o_sdata  out  DW  slave write data
o_ssel  out  SW  slave byte selects
i_sack  in  1  slave ACK
i_sdata  in  DW  slave read data
i_serr  in  1  slave ERR
o_grant  out  NM  one-hot registered grant, all zero when idle
o_timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (sync): state IDLE, o_grant=0, rr pointer=0, watchdog=0, o_timeout=0. Every output is 0 during and after reset until the first grant; o_mdata=0 when idle.
- States: IDLE, BUSY.
- IDLE: if any i_mcyc is set at a clock edge, grant the first requester at or after the pointer, scanning upward with wrap modulo NM. o_grant is updated and the state moves to BUSY at that edge.
  - Latency: master raises CYC in cycle 0, o_scyc is high in cycle 1.
- BUSY:
  - o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel are combinationally muxed from the granted master.
  - o_mack[g]=i_sack and o_merr[g]=i_serr|wd_fire. All other masters see ACK/ERR=0.
  - o_mdata=i_sdata.
- Release: when the granted master's i_mcyc is 0 at an edge, go to IDLE, clear o_grant and set pointer=(g+1) mod NM.
  - o_scyc is 0 combinationally in the cycle the master drops CYC.
  - There is always at least one IDLE cycle between two grants.
- Lock: other masters' requests never preempt the granted master, regardless of priority.
- Watchdog: counter increments each BUSY cycle with o_sstb=1, i_sack=0, i_serr=0. It clears when i_sack or i_serr is seen, when o_sstb=0, or in IDLE.
  - wd_fire is combinational: counter==TIMEOUT-1 with the same increment conditions true.
  - When wd_fire is true: o_merr[g]=1 for that cycle, the counter clears, and o_timeout pulses on the next cycle (registered).
  - The grant is retained; the master ends its cycle.
- Simultaneous i_sack and wd_fire: ACK has priority; wd_fire is suppressed.
- Simultaneous i_sack and i_serr: both are passed through unchanged.
- Reset mid-transaction: at the reset edge, grant and state clear. o_scyc and o_sstb are 0 from the next cycle. The transaction is abandoned with no ACK/ERR generated.
- Requests on the release edge: masters still requesting are considered at the next IDLE edge using the updated pointer.

Test Plan:
- Single master: NM=4, master 2 CYC/STB, read 0x00000010, slave ACK 2 cycles after o_scyc with data 0xDEADBEEF -> o_grant=4'b0100 one cycle after CYC; o_mack=4'b0100 and o_mdata=0xDEADBEEF in the ACK cycle; after CYC drops, o_grant=0 and pointer=3.
- Round robin: from reset, masters 0,1,3 hold CYC continuously and each drops CYC for one cycle after its ACK -> grant order 0,1,3,0,1,3; an IDLE cycle precedes each grant.
- Lock: master 1 granted with a burst of 4 STB/ACK beats while master 0 requests -> master 0 is not granted until master 1 drops CYC; master 1 receives exactly 4 ACKs.
- Watchdog: TIMEOUT=8, master 0 STB held, slave never ACKs -> o_merr[0]=1 in the 8th cycle with STB high, o_timeout=1 the next cycle, o_mack=0 throughout, grant held until CYC drops.
- ACK races timeout: TIMEOUT=8, slave ACKs in exactly the 8th STB cycle -> o_mack[0]=1, o_merr=0, o_timeout stays 0.
- Reset mid-cycle: master 3 granted with STB high, i_reset pulsed for 1 cycle -> o_scyc=0, o_grant=0 the following cycle; master 3 still requesting is re-granted at the first IDLE edge after reset (pointer=0, scan finds 3).

Source files
------------

// File: rtl/wbrrarbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port.
// Grants lock for the whole master cycle; a watchdog errors hung slaves.
module wbrrarbiter #(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    input  logic [NM-1:0]    i_mwe,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    input  logic [NM*SW-1:0] i_msel,
    output logic [NM-1:0]    o_mack,
    output logic [DW-1:0]    o_mdata,
    output logic [NM-1:0]    o_merr,
    output logic             o_scyc,
    output logic             o_sstb,
    output logic             o_swe,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    output logic [SW-1:0]    o_ssel,
    input  logic             i_sack,
    input  logic [DW-1:0]    i_sdata,
    input  logic             i_serr,
    output logic [NM-1:0]    o_grant,
    output logic             o_timeout
);
    localparam int IW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int WDW = 16;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_n;
    logic [NM-1:0]   grant_n;
    logic [IW-1:0]   gidx, gidx_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [WDW-1:0]  wd, wd_n;
    logic [NM-1:0]   pick;
    logic [IW-1:0]   pidx;
    logic            found;
    logic [IW:0]     scan;
    logic            cyc_g;
    logic            wd_inc;
    logic            wd_fire;

    // First requester at or after the pointer, wrapping modulo NM
    always_comb begin
        pick  = '0;
        pidx  = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NM; k++) begin
            scan = {1'b0, ptr} + (IW+1)'(k);
            if (scan >= (IW+1)'(NM))
                scan = scan - (IW+1)'(NM);
            if (!found && i_mcyc[scan[IW-1:0]]) begin
                found = 1'b1;
                pidx  = scan[IW-1:0];
            end
        end
        if (found)
            pick[pidx] = 1'b1;
    end

    assign cyc_g   = |(i_mcyc & o_grant);
    assign wd_inc  = (state == BUSY) && o_sstb && !i_sack && !i_serr;
    assign wd_fire = wd_inc && (wd == WDW'(TIMEOUT - 1));

    always_comb begin
        state_n = state;
        grant_n = o_grant;
        gidx_n  = gidx;
        ptr_n   = ptr;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    grant_n = pick;
                    gidx_n  = pidx;
                end
            end
            BUSY: begin
                if (!cyc_g) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = (gidx == IW'(NM - 1)) ? '0 : gidx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wd_n = '0;
        if (wd_inc && !wd_fire)
            wd_n = wd + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            o_grant   <= '0;
            gidx      <= '0;
            ptr       <= '0;
            wd        <= '0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_n;
            o_grant   <= grant_n;
            gidx      <= gidx_n;
            ptr       <= ptr_n;
            wd        <= wd_n;
            o_timeout <= wd_fire;
        end
    end

    // One-hot grant mux; zero grant forces every slave-side output low
    always_comb begin
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        for (int m = 0; m < NM; m++) begin
            if (o_grant[m]) begin
                o_scyc  = i_mcyc[m];
                o_sstb  = i_mcyc[m] & i_mstb[m];
                o_swe   = i_mwe[m];
                o_saddr = i_maddr[m*AW +: AW];
                o_sdata = i_mdata[m*DW +: DW];
                o_ssel  = i_msel[m*SW +: SW];
            end
        end
    end

    assign o_mack  = o_grant & {NM{i_sack}};
    assign o_merr  = o_grant & {NM{i_serr | wd_fire}};
    assign o_mdata = (state == BUSY) ? i_sdata : '0;

endmodule

// File: tb/tb_wbrrarbiter.sv
// Directed bench for wbrrarbiter: grant latency, rotation, lock,
// watchdog, ACK-vs-timeout race and mid-cycle reset.
module tb_wbrrarbiter;
    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic [NM-1:0]    i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0] i_maddr;
    logic [NM*DW-1:0] i_mdata;
    logic [NM*SW-1:0] i_msel;
    logic [NM-1:0]    o_mack, o_merr, o_grant;
    logic [DW-1:0]    o_mdata, o_sdata, i_sdata;
    logic             o_scyc, o_sstb, o_swe, o_timeout;
    logic [AW-1:0]    o_saddr;
    logic [SW-1:0]    o_ssel;
    logic             i_sack, i_serr;

    int ntests = 0;
    int nfail  = 0;
    int acks;

    wbrrarbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mack(o_mack), .o_mdata(o_mdata), .o_merr(o_merr),
        .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
        .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
        .i_sack(i_sack), .i_sdata(i_sdata), .i_serr(i_serr),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_mcyc  = '0;
        i_mstb  = '0;
        i_mwe   = '0;
        i_sack  = 1'b0;
        i_serr  = 1'b0;
        i_sdata = '0;
        step();
        step();
        i_reset = 1'b0;
    endtask

    initial begin
        int order[6] = '{0, 1, 3, 0, 1, 3};
        i_maddr = '0;
        i_mdata = '0;
        i_msel  = '0;
        do_reset();
        settle();
        check("rst_grant", 64'(o_grant), 64'h0);
        check("rst_scyc", 64'(o_scyc), 64'h0);
        check("rst_mdata", 64'(o_mdata), 64'h0);
        check("rst_tmo", 64'(o_timeout), 64'h0);

        // single master read
        step();
        i_mcyc[2] = 1'b1;
        i_mstb[2] = 1'b1;
        i_maddr[2*AW +: AW] = 32'h0000_0010;
        i_msel[2*SW +: SW]  = 4'hF;
        settle();
        check("c0_grant", 64'(o_grant), 64'h0);
        step();
        settle();
        check("c1_grant", 64'(o_grant), 64'h4);
        check("c1_scyc", 64'(o_scyc), 64'h1);
        check("c1_addr", 64'(o_saddr), 64'h10);
        check("c1_sel", 64'(o_ssel), 64'hF);
        check("c1_we", 64'(o_swe), 64'h0);
        step();
        settle();
        check("c2_ack", 64'(o_mack), 64'h0);
        step();
        i_sack  = 1'b1;
        i_sdata = 32'hDEAD_BEEF;
        settle();
        check("c3_ack", 64'(o_mack), 64'h4);
        check("c3_data", 64'(o_mdata), 64'hDEAD_BEEF);
        step();
        i_sack = 1'b0;
        i_mcyc = '0;
        i_mstb = '0;
        settle();
        check("drop_scyc", 64'(o_scyc), 64'h0);
        step();
        i_mcyc = 4'b1001;
        settle();
        check("rel_grant", 64'(o_grant), 64'h0);
        step();
        settle();
        check("ptr3_grant", 64'(o_grant), 64'h8);

        // round robin among 0,1,3
        do_reset();
        i_mcyc = 4'b1011;
        i_mstb = 4'b1011;
        i_sack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            settle();
            check("rr_grant", 64'(o_grant), 64'(1 << order[i]));
            check("rr_ack", 64'(o_mack), 64'(1 << order[i]));
            step();
            i_mcyc[order[i]] = 1'b0;
            settle();
            check("rr_drop", 64'(o_scyc), 64'h0);
            step();
            i_mcyc[order[i]] = 1'b1;
            settle();
            check("rr_idle", 64'(o_grant), 64'h0);
        end

        // lock: master 1 burst while master 0 requests
        do_reset();
        i_mcyc = 4'b0010;
        step();
        settle();
        check("lk_grant", 64'(o_grant), 64'h2);
        step();
        i_mcyc = 4'b0011;
        i_mstb = 4'b0011;
        i_sack = 1'b1;
        acks   = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("lk_hold", 64'(o_grant), 64'h2);
            check("lk_ack", 64'(o_mack), 64'h2);
            if (o_mack[1])
                acks++;
            step();
        end
        i_mstb = 4'b0001;
        i_sack = 1'b0;
        i_mcyc = 4'b0001;
        settle();
        check("lk_last", 64'(o_grant), 64'h2);
        step();
        settle();
        check("lk_idle", 64'(o_grant), 64'h0);
        step();
        settle();
        check("lk_next", 64'(o_grant), 64'h1);
        check("lk_acks", 64'(acks), 64'h4);

        // watchdog fires on the 8th stalled STB cycle
        do_reset();
        i_mcyc = 4'b0001;
        i_mstb = 4'b0001;
        step();
        for (int i = 1; i <= 8; i++) begin
            settle();
            check("wd_err", 64'(o_merr), (i == 8) ? 64'h1 : 64'h0);
            check("wd_ack", 64'(o_mack), 64'h0);
            check("wd_tmo", 64'(o_timeout), 64'h0);
            step();
        end
        settle();
        check("wd_pulse", 64'(o_timeout), 64'h1);
        check("wd_err9", 64'(o_merr), 64'h0);
        check("wd_hold", 64'(o_grant), 64'h1);
        step();
        i_mcyc = '0;
        i_mstb = '0;
        settle();
        check("wd_tmo10", 64'(o_timeout), 64'h0);
        step();
        settle();
        check("wd_rel", 64'(o_grant), 64'h0);

        // ACK lands in the 8th STB cycle
        do_reset();
        i_mcyc = 4'b0001;
        i_mstb = 4'b0001;
        step();
        for (int i = 1; i <= 8; i++) begin
            if (i == 8)
                i_sack = 1'b1;
            settle();
            check("race_err", 64'(o_merr), 64'h0);
            check("race_ack", 64'(o_mack), (i == 8) ? 64'h1 : 64'h0);
            step();
        end
        i_sack = 1'b0;
        i_mcyc = '0;
        i_mstb = '0;
        settle();
        check("race_tmo", 64'(o_timeout), 64'h0);

        // reset in the middle of master 3's cycle
        do_reset();
        i_mcyc = 4'b1000;
        i_mstb = 4'b1000;
        step();
        settle();
        check("mr_grant", 64'(o_grant), 64'h8);
        check("mr_stb", 64'(o_sstb), 64'h1);
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        settle();
        check("mr_scyc", 64'(o_scyc), 64'h0);
        check("mr_sstb", 64'(o_sstb), 64'h0);
        check("mr_clr", 64'(o_grant), 64'h0);
        step();
        settle();
        check("mr_regrant", 64'(o_grant), 64'h8);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
